apb_reg_slave: RTL and testbench

APB completer that answers the LPDDR testbench's APB initiator. It decodes word-aligned accesses on the 16-bit APB address into a bank of 32-bit configuration registers and inserts a programmable number of wait states via pready. It drives the register contents to the LPDDR controller model and pulses a per-register write strobe.

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_reg_bank.sv | 69 ++++++
 rtl/apb_reg_slave.sv | 123 ++++++++++++
 tb/tb_apb_reg_slave.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Purpose: shared APB definitions for the register-slave slice (widths, FSM states, ID default).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package apb_pkg;

    localparam int APB_ADDR_W = 16;
    localparam int APB_DATA_W = 32;

    // Word index is paddr[9:2], so at most 256 registers can be addressed.
    localparam int APB_IDX_W = 8;

    // Identification word returned by register 0.
    localparam logic [APB_DATA_W-1:0] APB_ID_VALUE = 32'h4C50_0001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } apb_slv_state_e;

endpackage

// File: rtl/apb_reg_bank.sv
// Purpose: 32-bit configuration register array with write decode, write strobes and read mux.
// Latency: write lands on cfg_o and wr_stb_o one cycle after wr_en; read mux is combinational.
// Backpressure: none; accepts a write every cycle wr_en is high.
//
// Ports:
//   pclk, preset      clock and synchronous active-high reset
//   wr_en/wr_idx/wr_dat  write request; index 0 and out-of-range indices are dropped
//   rd_idx/rd_dat     combinational read: ID for index 0, register contents, or 0 out of range
//   cfg_o             flat register image, reg i at [32i+31:32i]; slot 0 is always 0
//   wr_stb_o          one-cycle pulse on bit i after reg i is written
module apb_reg_bank
    import apb_pkg::*;
#(
    parameter int                    NUM_REGS = 16,
    parameter logic [APB_DATA_W-1:0] ID_VALUE = APB_ID_VALUE
) (
    input  logic                           pclk,
    input  logic                           preset,
    input  logic                           wr_en,
    input  logic [APB_IDX_W-1:0]           wr_idx,
    input  logic [APB_DATA_W-1:0]          wr_dat,
    input  logic [APB_IDX_W-1:0]           rd_idx,
    output logic [APB_DATA_W-1:0]          rd_dat,
    output logic [NUM_REGS*APB_DATA_W-1:0] cfg_o,
    output logic [NUM_REGS-1:0]            wr_stb_o
);

    // Entry 0 is never written: register 0 is the read-only ID, and its cfg_o slot stays 0.
    logic [APB_DATA_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_stb_o <= '0;
        end else begin
            wr_stb_o <= '0;
            // Decode starts at 1, so index 0 and indices >= NUM_REGS match nothing.
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_en && (wr_idx == APB_IDX_W'(i))) begin
                    regs_q[i]   <= wr_dat;
                    wr_stb_o[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_dat = '0;
        if (rd_idx == '0) begin
            rd_dat = ID_VALUE;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (rd_idx == APB_IDX_W'(i)) begin
                    rd_dat = regs_q[i];
                end
            end
        end
    end

    always_comb begin
        cfg_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cfg_o[i*APB_DATA_W +: APB_DATA_W] = regs_q[i];
        end
    end

endmodule

// File: rtl/apb_reg_slave.sv
// Purpose: APB completer decoding word accesses into a configuration register bank.
// Latency: pready rises WAIT_CYCLES+1 cycles after setup; write visible one cycle after pready.
// Backpressure: holds pready low for WAIT_CYCLES access cycles; no error response.
//
// Ports:
//   pclk, preset                         clock and synchronous active-high reset
//   paddr, pwdata, pwrite, psel, penable APB request; index = paddr[9:2]
//   pready, prdata                       registered completion and read data
//   cfg_o                                flat register image (NUM_REGS x 32)
//   wr_stb_o                             per-register write pulse, cycle after the write
module apb_reg_slave
    import apb_pkg::*;
#(
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_CYCLES = 0,
    parameter logic [APB_DATA_W-1:0] ID_VALUE    = APB_ID_VALUE
) (
    input  logic                           pclk,
    input  logic                           preset,
    input  logic [APB_ADDR_W-1:0]          paddr,
    input  logic [APB_DATA_W-1:0]          pwdata,
    input  logic                           pwrite,
    input  logic                           psel,
    input  logic                           penable,
    output logic                           pready,
    output logic [APB_DATA_W-1:0]          prdata,
    output logic [NUM_REGS*APB_DATA_W-1:0] cfg_o,
    output logic [NUM_REGS-1:0]            wr_stb_o
);

    apb_slv_state_e        state_q;
    logic [3:0]            cnt_q;
    logic [APB_IDX_W-1:0]  addr_q;
    logic                  wr_q;

    logic                  setup;
    logic                  wr_en;
    logic [APB_IDX_W-1:0]  rd_idx;
    logic [APB_DATA_W-1:0] rd_dat;

    // Only the word index matters; the remaining address bits are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{paddr[APB_ADDR_W-1:10], paddr[1:0]};

    assign setup = psel && !penable;

    // With zero wait states READY is entered straight from the setup cycle, before addr_q
    // holds the index, so the read mux must look at the live address in IDLE.
    assign rd_idx = (state_q == IDLE) ? paddr[9:2] : addr_q;

    // pwdata is taken in the completing cycle, not at setup.
    assign wr_en = (state_q == READY) && psel && penable && wr_q;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            pready  <= 1'b0;
            prdata  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    pready <= 1'b0;
                    prdata <= '0;
                    if (setup) begin
                        addr_q <= paddr[9:2];
                        wr_q   <= pwrite;
                        cnt_q  <= 4'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            state_q <= READY;
                            pready  <= 1'b1;
                            prdata  <= rd_dat;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Abort takes priority over the countdown.
                    if (!psel) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_q <= READY;
                            pready  <= 1'b1;
                            prdata  <= rd_dat;
                        end
                    end
                end
                READY: begin
                    state_q <= IDLE;
                    pready  <= 1'b0;
                    prdata  <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    pready  <= 1'b0;
                    prdata  <= '0;
                end
            endcase
        end
    end

    apb_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .ID_VALUE (ID_VALUE)
    ) u_bank (
        .pclk     (pclk),
        .preset   (preset),
        .wr_en    (wr_en),
        .wr_idx   (addr_q),
        .wr_dat   (pwdata),
        .rd_idx   (rd_idx),
        .rd_dat   (rd_dat),
        .cfg_o    (cfg_o),
        .wr_stb_o (wr_stb_o)
    );

endmodule

// File: tb/tb_apb_reg_slave.sv
// Purpose: scoreboard bench for apb_reg_slave with zero and three wait states.
// Latency: n/a.
// Backpressure: n/a.
module tb_apb_reg_slave;

    localparam int          NR = 16;
    localparam logic [31:0] ID = 32'h4C50_0001;

    logic               pclk;
    logic               preset;
    logic [15:0]        paddr   [2];
    logic [31:0]        pwdata  [2];
    logic               pwrite  [2];
    logic               psel    [2];
    logic               penable [2];
    logic               pready  [2];
    logic [31:0]        prdata  [2];
    logic [NR*32-1:0]   cfg     [2];
    logic [NR-1:0]      wr_stb  [2];

    apb_reg_slave #(.NUM_REGS(NR), .WAIT_CYCLES(0), .ID_VALUE(ID)) u_dut0 (
        .pclk(pclk), .preset(preset), .paddr(paddr[0]), .pwdata(pwdata[0]),
        .pwrite(pwrite[0]), .psel(psel[0]), .penable(penable[0]), .pready(pready[0]),
        .prdata(prdata[0]), .cfg_o(cfg[0]), .wr_stb_o(wr_stb[0])
    );

    apb_reg_slave #(.NUM_REGS(NR), .WAIT_CYCLES(3), .ID_VALUE(ID)) u_dut1 (
        .pclk(pclk), .preset(preset), .paddr(paddr[1]), .pwdata(pwdata[1]),
        .pwrite(pwrite[1]), .psel(psel[1]), .penable(penable[1]), .pready(pready[1]),
        .prdata(prdata[1]), .cfg_o(cfg[1]), .wr_stb_o(wr_stb[1])
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        int          d;
        bit          wr;
        bit          valid;
        int          idx;
        logic [31:0] rd;
        logic [31:0] old;
        int          waits;
    } xfer_t;

    typedef struct {
        int          d;
        int          idx;
        logic [31:0] dat;
    } stb_t;

    xfer_t       xq[$];
    stb_t        sq[$];
    logic [31:0] model [2][NR];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_rd(input int d, input int idx);
        if (idx == 0)  return ID;
        if (idx < NR)  return model[d][idx];
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NR; i++)
                model[d][i] = 32'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    // Called just after a rising edge; returns just after a rising edge with the bus idle.
    task automatic xfer(input int d, input bit wr, input logic [15:0] addr, input logic [31:0] data);
        xfer_t e;
        stb_t  s;
        int    idx;
        int    n;
        idx     = int'(addr[9:2]);
        e.d     = d;
        e.wr    = wr;
        e.idx   = idx;
        e.valid = (idx >= 1) && (idx < NR);
        e.rd    = model_rd(d, idx);
        e.old   = e.valid ? model[d][idx] : 32'h0;
        e.waits = (d == 0) ? 0 : 3;
        xq.push_back(e);
        if (wr && e.valid) begin
            s.d = d; s.idx = idx; s.dat = data;
            sq.push_back(s);
            model[d][idx] = data;
        end
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        paddr[d]   = addr;
        pwrite[d]  = wr;
        pwdata[d]  = $urandom;      // junk at setup: data must be taken at completion
        @(posedge pclk); #1;
        penable[d] = 1'b1;
        pwdata[d]  = data;
        n = 0;
        forever begin
            @(negedge pclk);
            if (pready[d]) break;
            n++;
            if (n > 40) break;
            @(posedge pclk); #1;
        end
        chk("xfer_timeout", 32'(n > 40), 32'd0);
        @(posedge pclk); #1;
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
    endtask

    // Monitor: pops expected responses whenever a DUT completes or strobes.
    int wcnt     [2];
    int last_rdy [2];
    initial begin
        xfer_t e;
        stb_t  s;
        wcnt[0] = 0; wcnt[1] = 0; last_rdy[0] = -10; last_rdy[1] = -10;
        forever begin
            @(negedge pclk);
            for (int d = 0; d < 2; d++) begin
                if (preset) begin
                    wcnt[d] = 0;
                end else begin
                    if (pready[d]) begin
                        last_rdy[d] = cyc;
                        if (xq.size() == 0) begin
                            chk("pready_unexpected", 32'(pready[d]), 32'd0);
                        end else begin
                            e = xq.pop_front();
                            chk("xfer_dut", 32'(d), 32'(e.d));
                            chk("wait_states", 32'(wcnt[d]), 32'(e.waits));
                            if (!e.wr)
                                chk("prdata", prdata[d], e.rd);
                            else if (e.valid)
                                chk("no_early_write", cfg[d][e.idx*32 +: 32], e.old);
                        end
                        wcnt[d] = 0;
                    end else begin
                        chk("prdata_idle", prdata[d], 32'h0);
                        if (psel[d] && penable[d]) wcnt[d]++;
                        else                       wcnt[d] = 0;
                    end
                    if (wr_stb[d] != '0) begin
                        if (sq.size() == 0) begin
                            chk("strobe_unexpected", 32'(wr_stb[d]), 32'd0);
                        end else begin
                            s = sq.pop_front();
                            chk("stb_dut", 32'(d), 32'(s.d));
                            chk("stb_bits", 32'(wr_stb[d]), 32'(16'(1) << s.idx));
                            chk("stb_cfg", cfg[d][s.idx*32 +: 32], s.dat);
                            chk("stb_timing", 32'(cyc - last_rdy[d]), 32'd1);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        int          idx;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; paddr[d] = 16'h0;
            pwdata[d] = 32'h0; pwrite[d] = 1'b0;
        end
        preset = 1'b1;
        repeat (3) @(posedge pclk);
        #1 preset = 1'b0;

        // Reset state.
        @(negedge pclk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_pready", 32'(pready[d]), 32'd0);
            chk("rst_prdata", prdata[d], 32'h0);
            chk("rst_wr_stb", 32'(wr_stb[d]), 32'd0);
            for (int i = 0; i < NR; i++)
                chk("rst_cfg", cfg[d][i*32 +: 32], 32'h0);
        end
        @(posedge pclk); #1;

        // Zero wait states: ID read, write/read back, ignored writes.
        xfer(0, 1'b0, 16'h0000, 32'h0);
        xfer(0, 1'b1, 16'h0008, 32'hA5A5_1234);
        xfer(0, 1'b0, 16'h0008, 32'h0);
        xfer(0, 1'b1, 16'h0000, 32'hFFFF_FFFF);
        xfer(0, 1'b1, 16'h0040, 32'hFFFF_FFFF);
        xfer(0, 1'b0, 16'h0000, 32'h0);
        xfer(0, 1'b0, 16'h0040, 32'h0);
        idle(2);
        chk("cfg_reg2", cfg[0][95:64], 32'hA5A5_1234);

        // Three wait states.
        xfer(1, 1'b1, 16'h0004, 32'h1357_9BDF);
        xfer(1, 1'b0, 16'h0004, 32'h0);

        // Abort a write after one wait cycle.
        psel[1] = 1'b1; penable[1] = 1'b0; paddr[1] = 16'h0014;
        pwrite[1] = 1'b1; pwdata[1] = 32'hDEAD_BEEF;
        @(posedge pclk); #1;
        penable[1] = 1'b1;
        @(posedge pclk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        idle(6);
        chk("abort_reg5", cfg[1][5*32 +: 32], model[1][5]);

        // Reset during the wait phase of a write to reg 3.
        psel[1] = 1'b1; penable[1] = 1'b0; paddr[1] = 16'h000C;
        pwrite[1] = 1'b1; pwdata[1] = 32'h5555_AAAA;
        @(posedge pclk); #1;
        penable[1] = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b1;
        model_reset();
        @(posedge pclk); #1;
        preset = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
        @(negedge pclk);
        chk("mid_rst_pready", 32'(pready[1]), 32'd0);
        chk("mid_rst_prdata", prdata[1], 32'h0);
        chk("mid_rst_wr_stb", 32'(wr_stb[1]), 32'd0);
        chk("mid_rst_reg3", cfg[1][3*32 +: 32], 32'h0);
        chk("mid_rst_reg1", cfg[1][1*32 +: 32], 32'h0);
        @(posedge pclk); #1;
        xfer(1, 1'b1, 16'h000C, 32'hCAFE_F00D);
        xfer(1, 1'b0, 16'h000C, 32'h0);

        // Randomized traffic, mostly back-to-back.
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 7) == 0) idx = int'($urandom_range(16, 255));
            else                           idx = int'($urandom_range(0, 15));
            a = {6'($urandom), 8'(idx), 2'($urandom)};
            xfer(int'($urandom_range(0, 1)), 1'($urandom), a, $urandom);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end

        idle(4);
        chk("xfers_left", 32'(xq.size()), 32'd0);
        chk("strobes_left", 32'(sq.size()), 32'd0);
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NR; i++)
                chk("final_cfg", cfg[d][i*32 +: 32], model[d][i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
